// File: rtl/btree_pkg.sv
// btree_pkg: shared node layout, load field indices and FSM states for the B-tree search sequencer.
package btree_pkg;

    localparam logic [7:0] NULL_ADDR = 8'd0;

    localparam logic [3:0] FIELD_KEY1  = 4'd0;
    localparam logic [3:0] FIELD_KEY2  = 4'd1;
    localparam logic [3:0] FIELD_KEY3  = 4'd2;
    localparam logic [3:0] FIELD_DATA1 = 4'd3;
    localparam logic [3:0] FIELD_DATA2 = 4'd4;
    localparam logic [3:0] FIELD_DATA3 = 4'd5;
    localparam logic [3:0] FIELD_NEXT0 = 4'd6;
    localparam logic [3:0] FIELD_NEXT1 = 4'd7;
    localparam logic [3:0] FIELD_NEXT2 = 4'd8;
    localparam logic [3:0] FIELD_NEXT3 = 4'd9;

    // index 0 of each array is key1 / data1 / next0
    typedef struct packed {
        logic [2:0][7:0] key;
        logic [2:0][7:0] data;
        logic [3:0][7:0] next;
    } node_t;

    typedef enum logic [1:0] {IDLE, READ, CMP, DONE} state_t;

endpackage

// File: rtl/btree_if.sv
// btree_if: load, request and response channels between a lookup requester and the sequencer.
interface btree_if;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_node;
    logic [3:0] load_field;
    logic [7:0] load_value;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_key;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_found;
    logic [7:0] rsp_data;
    logic       rsp_error;
    logic [3:0] rsp_steps;

    modport master (
        output load_valid, load_node, load_field, load_value, req_valid, req_key, rsp_ready,
        input  load_ready, req_ready, rsp_valid, rsp_found, rsp_data, rsp_error, rsp_steps
    );

    modport slave (
        input  load_valid, load_node, load_field, load_value, req_valid, req_key, rsp_ready,
        output load_ready, req_ready, rsp_valid, rsp_found, rsp_data, rsp_error, rsp_steps
    );
endinterface

// File: rtl/btree_node_compare.sv
// btree_node_compare: one-node key match and child selection, shared by every tree level.
module btree_node_compare
    import btree_pkg::*;
(
    input  node_t      node,
    input  logic [7:0] key,
    output logic       found,
    output logic [7:0] data,
    output logic [7:0] child
);
    logic [2:0] eq;
    logic [2:0] lt;
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            eq[i] = node.key[i] == key;
            lt[i] = node.key[i] < key;
        end
    end
    assign found = |eq;
    // lowest matching slot wins when keys repeat
    assign data  = eq[0] ? node.data[0] : eq[1] ? node.data[1] : eq[2] ? node.data[2] : 8'd0;
    assign child = node.next[2'(lt[0]) + 2'(lt[1]) + 2'(lt[2])];
endmodule

// File: rtl/btree_search_sequencer.sv
// btree_search_sequencer: walks a 3-key/4-child B-tree one level per READ/CMP pair
// using a single compare unit; owns the node storage and its load port.
module btree_search_sequencer
    import btree_pkg::*;
#(
    parameter int pNodes    = 16,
    parameter int pRoot     = 1,
    parameter int pMaxDepth = 8
) (
    input logic     clock,
    input logic     reset,
    btree_if.slave  bus
);
    localparam int         AW  = $clog2(pNodes);
    localparam logic [8:0] LIM = 9'(pNodes);

    node_t      mem [pNodes];
    node_t      cur;
    state_t     state;
    logic [7:0] key;
    logic [7:0] addr;
    logic [3:0] steps;
    logic       hit;
    logic [7:0] hit_data;
    logic [7:0] child;
    logic       load_ok;

    btree_node_compare u_cmp (
        .node  (cur),
        .key   (key),
        .found (hit),
        .data  (hit_data),
        .child (child)
    );

    assign bus.load_ready = state == IDLE;
    assign bus.req_ready  = state == IDLE && !bus.load_valid;
    assign load_ok = bus.load_valid && bus.load_ready && bus.load_node != NULL_ADDR
                     && {1'b0, bus.load_node} < LIM && bus.load_field <= FIELD_NEXT3;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < pNodes; i++) mem[i] <= '0;
        end else if (load_ok) begin
            if (bus.load_field < FIELD_DATA1)
                mem[bus.load_node[AW-1:0]].key[bus.load_field[1:0]] <= bus.load_value;
            else if (bus.load_field < FIELD_NEXT0)
                mem[bus.load_node[AW-1:0]].data[2'(bus.load_field - FIELD_DATA1)] <= bus.load_value;
            else
                mem[bus.load_node[AW-1:0]].next[2'(bus.load_field - FIELD_NEXT0)] <= bus.load_value;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            cur           <= '0;
            key           <= '0;
            addr          <= '0;
            steps         <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_found <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_error <= 1'b0;
            bus.rsp_steps <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid && bus.req_ready) begin
                    key   <= bus.req_key;
                    addr  <= 8'(pRoot);
                    steps <= '0;
                    state <= READ;
                end
                READ: if ({1'b0, addr} >= LIM) begin
                    bus.rsp_found <= 1'b0;
                    bus.rsp_data  <= '0;
                    bus.rsp_error <= 1'b1;
                    bus.rsp_steps <= steps;
                    state         <= DONE;
                end else begin
                    cur   <= mem[addr[AW-1:0]];
                    steps <= steps + 4'd1;
                    state <= CMP;
                end
                CMP: begin
                    bus.rsp_found <= hit;
                    bus.rsp_data  <= hit_data;
                    bus.rsp_steps <= steps;
                    bus.rsp_error <= !hit && child != NULL_ADDR && steps == 4'(pMaxDepth);
                    if (hit || child == NULL_ADDR || steps == 4'(pMaxDepth)) begin
                        state <= DONE;
                    end else begin
                        addr  <= child;
                        state <= READ;
                    end
                end
                DONE: if (!bus.rsp_valid) begin
                    bus.rsp_valid <= 1'b1;
                end else if (bus.rsp_ready) begin
                    bus.rsp_valid <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
